grain_flex_prog_loader: RTL and testbench
=========================================

# grain_flex_prog_loader

Bitstream loader that sits directly upstream of the GrainFlex fabric programming interface. It accepts configuration bytes over a valid/ready stream and clears the configuration chain. It then serializes the bytes LSB-first onto the chain's clock/enable/data pins at a divided bit rate. Bits shifted out of the chain tail are captured and returned as readback bytes. Its outputs drive the fabric's `io_progIface_*` pins in place of raw pad signals.

## Interface

Parameters:

- `CHAIN_LEN`, 1024: total configuration chain length in bits (≥1).
- `CLK_DIV`, 2: `clk` cycles per prog_clk phase (≥1); one bit period = 2·CLK_DIV cycles.
- `RST_CYCLES`, 8: `clk` cycles prog_rst is held high at load start (≥1).

Ports:

- `clk`, in, 1: the single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: pulse; begins a load when in IDLE or DONE.
- `abort`, in, 1: pulse; cancels any operation.
- `in_data`, in, 8: configuration byte, bit 0 shifted first.
- `in_valid`, in, 1: in_data valid.
- `in_ready`, out, 1: loader can accept a byte.
- `rb_data`, out, 8: readback byte; first captured bit in bit 0.
- `rb_valid`, out, 1: one-cycle pulse; no backpressure.
- `prog_clk`, out, 1: to io_progIface_clk.
- `prog_rst`, out, 1: to io_progIface_reset.
- `prog_en`, out, 1: to io_progIface_en.
- `prog_din`, out, 1: to io_progIface_dIn.
- `prog_dout`, in, 1: from io_progIface_dOut (chain tail).
- `busy`, out, 1: high in CLEAR, LOAD, SHIFT.
- `done`, out, 1: high in DONE.

## Operation

- States: IDLE, CLEAR, LOAD, SHIFT, DONE.
- IDLE, start=1: go to CLEAR. Zero the bit counter (width $clog2(CHAIN_LEN+1)).
- CLEAR: prog_rst=1 for exactly RST_CYCLES cycles, then go to LOAD.
- LOAD: in_ready=1. On in_valid&in_ready, latch the byte and go to SHIFT. Set nbits = min(8, CHAIN_LEN − count).
- SHIFT: prog_en=1. For each of nbits bits:
  - Low phase, CLK_DIV cycles: prog_clk=0, prog_din=current bit. prog_dout is sampled on the last low-phase cycle into the readback register at that bit's position.
  - High phase, CLK_DIV cycles: prog_clk=1; count increments at the end.
- After the last bit, rb_valid pulses with rb_data; unused upper bits are 0.
  - count==CHAIN_LEN: go to DONE.
  - Otherwise: go to LOAD.
- Extra bits of a partial final byte are discarded.
- DONE: done=1, prog_en=0, in_ready=0. start re-enters CLEAR and clears done.
- start while busy: ignored.
- abort: highest priority over start and in_valid. Next state is IDLE; any pending rb_valid is suppressed.
- reset: all state and outputs go to 0 immediately, mid-bit included.

## Timing

- Reset values: every output is 0, including prog_clk, prog_en, prog_rst, in_ready.
- start → prog_rst high: 1 cycle.
- prog_rst falls → in_ready high: the same edge.
- Byte accept → first prog_clk rise: CLK_DIV cycles.
- Per full byte: 16·CLK_DIV cycles in SHIFT plus 1 LOAD cycle minimum.
- rb_valid: asserted the cycle after the final high phase ends, concurrent with the return to LOAD (in_ready=1) or entry to DONE.
- prog_din and prog_en: stable across every prog_clk rising edge (changed only during the low phase).
- prog_clk: registered, glitch-free, 50% duty cycle.

## Structure

- Package `grain_flex_prog_pkg`:
  - state enum `prog_state_t`;
  - `PROG_BYTE_W = 8`;
  - the count-width function.
- One sub-module, `grain_flex_prog_bitclk`:
  - phase counter with inputs run and CLK_DIV;
  - emits prog_clk, a sample_tick (last low cycle) and a bit_done tick (last high cycle).
- FSM, byte/readback shift registers and counter live in the top.

## Test plan

All scenarios use CHAIN_LEN=12, CLK_DIV=2, RST_CYCLES=8 unless stated.

- Reset/idle: assert reset mid-SHIFT → all outputs 0 the same cycle; after release, IDLE with in_ready=0.
- Full load: start, bytes 0xA5 then 0x0F, with a chain model of 12 flops preloaded 0xFFF before CLEAR. Required response:
  - prog_rst high 8 cycles;
  - 12 prog_clk rises;
  - chain holds 0xFA5 (first bit deepest);
  - rb_valid twice, rb_data 0x00 then 0x00, since CLEAR zeroed the chain;
  - done=1, second byte's upper 4 bits discarded.
- Readback without clear: a model that ignores prog_rst and is preloaded 0x5A3 → first rb_data=0xA3, second rb_data=0x05.
- Backpressure: in_valid held low 20 cycles in LOAD → prog_clk static, prog_en=0, no count change; then resumes correctly.
- Abort: abort during bit 3 of byte 1 → IDLE next cycle, prog_en=0, no rb_valid; a subsequent start performs a full clean load.
- Divider extremes: CLK_DIV=1, CHAIN_LEN=8, one byte → exactly 16 SHIFT cycles, one rb_valid, done=1; start while busy has no effect.

Source files
------------

// File: rtl/grain_flex_prog_pkg.sv
// Shared types and helpers for the GrainFlex configuration-chain loader.
// The state enum, byte width and bit-counter width live here so every file agrees.
package grain_flex_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } prog_state_t;

    localparam int PROG_BYTE_W = 8;

    function automatic int count_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/grain_flex_prog_bitclk.sv
// Bit-period generator: CLK_DIV low cycles followed by CLK_DIV high cycles of prog_clk,
// with a tick on the last low cycle (sample point) and on the last high cycle (bit end).
module grain_flex_prog_bitclk #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_prog_clk,
    output logic o_sample_tick,
    output logic o_bit_done
);

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] LOW_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] HIGH_LAST = PW'(2 * CLK_DIV - 1);

    logic [PW-1:0] r_phase;
    logic          r_clk;

    assign o_sample_tick = i_run && (r_phase == LOW_LAST);
    assign o_bit_done    = i_run && (r_phase == HIGH_LAST);
    assign o_prog_clk    = r_clk;

    // Dropping run parks the divider at the start of a low phase with prog_clk low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
            r_clk   <= 1'b0;
        end else if (!i_run) begin
            r_phase <= '0;
            r_clk   <= 1'b0;
        end else begin
            r_phase <= o_bit_done ? '0 : r_phase + PW'(1);
            r_clk   <= o_sample_tick || (r_clk && !o_bit_done);
        end
    end

endmodule

// File: rtl/grain_flex_prog_loader.sv
// Streams configuration bytes LSB-first into the GrainFlex programming chain after a
// chain reset, and returns the bits that fall out of the chain tail as readback bytes.
module grain_flex_prog_loader
    import grain_flex_prog_pkg::*;
#(
    parameter int CHAIN_LEN  = 1024,
    parameter int CLK_DIV    = 2,
    parameter int RST_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PROG_BYTE_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [PROG_BYTE_W-1:0] rb_data,
    output logic                   rb_valid,
    output logic                   prog_clk,
    output logic                   prog_rst,
    output logic                   prog_en,
    output logic                   prog_din,
    input  logic                   prog_dout,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = count_width(CHAIN_LEN);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    prog_state_t            r_state;
    logic [CW-1:0]          r_count;
    logic [RW-1:0]          r_rstCnt;
    logic [PROG_BYTE_W-1:0] r_shift;
    logic [PROG_BYTE_W-1:0] r_rb;
    logic [PROG_BYTE_W-1:0] r_rbData;
    logic [2:0]             r_bitIdx;
    logic [2:0]             r_lastIdx;
    logic                   r_inReady;
    logic                   r_rbValid;
    logic                   r_progRst;
    logic                   r_progEn;
    logic                   r_busy;
    logic                   r_done;

    logic        w_run;
    logic        w_sampleTick;
    logic        w_bitDone;
    logic [31:0] w_remain;
    logic [2:0]  w_lastIdx;
    logic        w_lastBit;
    logic        w_chainFull;

    assign w_run = (r_state == ST_SHIFT) && !abort;

    grain_flex_prog_bitclk #(
        .CLK_DIV(CLK_DIV)
    ) u_bitclk (
        .clk          (clk),
        .reset        (reset),
        .i_run        (w_run),
        .o_prog_clk   (prog_clk),
        .o_sample_tick(w_sampleTick),
        .o_bit_done   (w_bitDone)
    );

    // A short final byte only shifts the bits still missing from the chain.
    always_comb begin
        w_remain    = 32'(CHAIN_LEN) - 32'(r_count);
        w_lastIdx   = (w_remain >= 32'd8) ? 3'd7 : 3'(w_remain - 32'd1);
        w_lastBit   = (r_bitIdx == r_lastIdx);
        w_chainFull = ((32'(r_count) + 32'd1) == 32'(CHAIN_LEN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_rstCnt  <= '0;
            r_shift   <= '0;
            r_rb      <= '0;
            r_rbData  <= '0;
            r_bitIdx  <= '0;
            r_lastIdx <= '0;
            r_inReady <= 1'b0;
            r_rbValid <= 1'b0;
            r_progRst <= 1'b0;
            r_progEn  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rbValid <= 1'b0;
            if (abort) begin
                r_state   <= ST_IDLE;
                r_shift   <= '0;
                r_inReady <= 1'b0;
                r_progRst <= 1'b0;
                r_progEn  <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            r_state   <= ST_CLEAR;
                            r_count   <= '0;
                            r_rstCnt  <= '0;
                            r_progRst <= 1'b1;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        r_rstCnt <= r_rstCnt + RW'(1);
                        if (r_rstCnt == RST_LAST) begin
                            r_state   <= ST_LOAD;
                            r_progRst <= 1'b0;
                            r_inReady <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (in_valid) begin
                            r_state   <= ST_SHIFT;
                            r_shift   <= in_data;
                            r_rb      <= '0;
                            r_bitIdx  <= '0;
                            r_lastIdx <= w_lastIdx;
                            r_inReady <= 1'b0;
                            r_progEn  <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_sampleTick) begin
                            r_rb[r_bitIdx] <= prog_dout;
                        end
                        if (w_bitDone) begin
                            r_count  <= r_count + CW'(1);
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= r_shift >> 1;
                            if (w_lastBit) begin
                                r_shift   <= '0;
                                r_progEn  <= 1'b0;
                                r_rbValid <= 1'b1;
                                r_rbData  <= r_rb;
                                if (w_chainFull) begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state   <= ST_LOAD;
                                    r_inReady <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready = r_inReady;
    assign rb_data  = r_rbData;
    assign rb_valid = r_rbValid;
    assign prog_rst = r_progRst;
    assign prog_en  = r_progEn;
    assign prog_din = r_shift[0];
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_grain_flex_prog_loader.sv
// Self-checking bench for grain_flex_prog_loader: a behavioural configuration-chain
// model feeds prog_dout, and each load is judged against values derived from the bytes sent.
module tb_grain_flex_prog_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] inData = 8'h00;
   logic       inValid = 1'b0;
   logic       inReady, rbValid, progClk, progRst, progEn, progDin, progDout, busy, done;
   logic [7:0] rbData;

   logic       fStart = 1'b0;
   logic       fAbort = 1'b0;
   logic [7:0] fInData = 8'h00;
   logic       fInValid = 1'b0;
   logic       fInReady, fRbValid, fProgClk, fProgRst, fProgEn, fProgDin, fProgDout, fBusy, fDone;
   logic [7:0] fRbData;

   int totalChecks = 0;
   int badChecks = 0;

   // Chain models: bit 0 is the tail, new bits enter at the head on each prog_clk rise.
   logic [11:0] chain = 12'h000;
   logic [7:0]  fChain = 8'h00;
   logic        honorRst = 1'b1;
   logic        preloadReq = 1'b0;
   logic [11:0] preloadVal = 12'h000;
   logic        fPreloadReq = 1'b0;
   logic [7:0]  fPreloadVal = 8'h00;
   int riseCnt = 0, rstCyc = 0, enCyc = 0, stabViol = 0;
   int fRiseCnt = 0, fRstCyc = 0, fEnCyc = 0, fStabViol = 0;
   logic [7:0] rbQ[$];
   logic [7:0] fRbQ[$];
   logic prevClk = 1'b0, prevDin = 1'b0, prevEn = 1'b0;
   logic fPrevClk = 1'b0, fPrevDin = 1'b0, fPrevEn = 1'b0;

   assign progDout  = chain[0];
   assign fProgDout = fChain[0];

   grain_flex_prog_loader #(.CHAIN_LEN(12), .CLK_DIV(2), .RST_CYCLES(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .in_data(inData), .in_valid(inValid), .in_ready(inReady),
      .rb_data(rbData), .rb_valid(rbValid),
      .prog_clk(progClk), .prog_rst(progRst), .prog_en(progEn), .prog_din(progDin),
      .prog_dout(progDout), .busy(busy), .done(done)
   );

   grain_flex_prog_loader #(.CHAIN_LEN(8), .CLK_DIV(1), .RST_CYCLES(8)) u_fast (
      .clk(clk), .reset(reset), .start(fStart), .abort(fAbort),
      .in_data(fInData), .in_valid(fInValid), .in_ready(fInReady),
      .rb_data(fRbData), .rb_valid(fRbValid),
      .prog_clk(fProgClk), .prog_rst(fProgRst), .prog_en(fProgEn), .prog_din(fProgDin),
      .prog_dout(fProgDout), .busy(fBusy), .done(fDone)
   );

   // Fabric-side observation: shift the chain on prog_clk rises, count pins, collect readback.
   always @(negedge clk) begin
      if (preloadReq) chain = preloadVal;
      else if (progRst && honorRst) chain = 12'h000;
      if (progClk && !prevClk) begin
         riseCnt++;
         if (progEn) chain = {progDin, chain[11:1]};
      end
      if (progClk && prevClk && (progDin != prevDin || progEn != prevEn)) stabViol++;
      if (progRst) rstCyc++;
      if (progEn) enCyc++;
      if (rbValid) rbQ.push_back(rbData);
      prevClk = progClk;
      prevDin = progDin;
      prevEn  = progEn;

      if (fPreloadReq) fChain = fPreloadVal;
      if (fProgClk && !fPrevClk) begin
         fRiseCnt++;
         if (fProgEn) fChain = {fProgDin, fChain[7:1]};
      end
      if (fProgClk && fPrevClk && (fProgDin != fPrevDin || fProgEn != fPrevEn)) fStabViol++;
      if (fProgRst) fRstCyc++;
      if (fProgEn) fEnCyc++;
      if (fRbValid) fRbQ.push_back(fRbData);
      fPrevClk = fProgClk;
      fPrevDin = fProgDin;
      fPrevEn  = fProgEn;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Waits for in_ready, holds the byte back for gap cycles, then hands it over.
   task automatic sendByte(input logic [7:0] b, input int gap, output int waitCycles, output logic rbAtReady);
      waitCycles = 0;
      while (!inReady && waitCycles < 60) begin
         tick();
         waitCycles++;
      end
      checkOutput("ready_seen", {inReady, progRst}, 2'b10);
      rbAtReady = rbValid;
      for (int i = 0; i < gap; i++) begin
         checkOutput("bp_idle", {progEn, progClk, inReady, busy}, 4'b0011);
         tick();
      end
      inData = b;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      checkOutput("accept", {progEn, progClk, inReady}, 3'b100);
   endtask

   // One complete load of a 12-bit chain: byte b0 plus the low nibble of b1.
   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [11:0] pre,
                                input logic honor, input int gap);
      int r0, s0, e0, v0, q0, n;
      logic rbAt;
      logic [7:0] exp0, exp1;
      honorRst = honor;
      preloadVal = pre;
      preloadReq = 1'b1;
      tick();
      preloadReq = 1'b0;
      r0 = riseCnt; s0 = rstCyc; e0 = enCyc; v0 = stabViol; q0 = rbQ.size();
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("rst_rise", {progRst, busy, done}, 3'b110);
      sendByte(b0, 0, n, rbAt);
      checkOutput("clear_len", n, 8);
      checkOutput("rb_first_idle", rbAt, 0);
      sendByte(b1, gap, n, rbAt);
      checkOutput("shift_len", n, 32);
      checkOutput("rb_with_load", rbAt, 1);
      n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      checkOutput("done_state", {done, busy, inReady, progEn, rbValid}, 5'b10001);
      checkOutput("last_shift_len", n, 16);
      exp0 = honor ? 8'h00 : pre[7:0];
      exp1 = honor ? 8'h00 : {4'h0, pre[11:8]};
      checkOutput("rise_cnt", riseCnt - r0, 12);
      checkOutput("rst_cycles", rstCyc - s0, 8);
      checkOutput("en_cycles", enCyc - e0, 48);
      checkOutput("din_stable", stabViol - v0, 0);
      checkOutput("rb_count", rbQ.size() - q0, 2);
      if (rbQ.size() >= q0 + 2) begin
         checkOutput("rb_byte0", rbQ[q0], exp0);
         checkOutput("rb_byte1", rbQ[q0+1], exp1);
      end
      checkOutput("chain", chain, {b1[3:0], b0});
   endtask

   initial begin
      int n, r0, q0, s0, e0, v0;
      logic rbAt;
      logic [7:0] fb;

      #1;
      checkOutput("reset_outputs", {progClk, progRst, progEn, progDin, inReady, rbValid, busy, done, rbData}, 16'h0000);
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      checkOutput("idle_after_reset", {inReady, busy, done, progEn, progRst}, 5'b00000);

      applyStimulus(8'hA5, 8'h0F, 12'hFFF, 1'b1, 0);
      applyStimulus(8'($urandom), 8'($urandom), 12'h5A3, 1'b0, 0);
      applyStimulus(8'($urandom), 8'($urandom), 12'($urandom), 1'b1, 20);
      for (int k = 0; k < 3; k++)
         applyStimulus(8'($urandom), 8'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 5));

      // Abort in the middle of bit 3 of the first byte.
      r0 = riseCnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      sendByte(8'($urandom), 0, n, rbAt);
      n = 0;
      while (!((riseCnt - r0) == 3 && !progClk) && n < 200) begin
         tick();
         n++;
      end
      checkOutput("abort_reach", riseCnt - r0, 3);
      q0 = rbQ.size();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_idle", {busy, progEn, progClk, inReady, done, progRst}, 6'b000000);
      repeat (40) tick();
      checkOutput("abort_no_rb", rbQ.size() - q0, 0);
      checkOutput("abort_stays", {busy, progEn, riseCnt - r0}, {2'b00, 32'd3});
      applyStimulus(8'($urandom), 8'($urandom), 12'($urandom), 1'b1, 2);

      // Fast divider on an 8-bit chain, with start pulses that must be ignored while busy.
      fb = 8'($urandom);
      fPreloadVal = 8'($urandom);
      fPreloadReq = 1'b1;
      tick();
      fPreloadReq = 1'b0;
      r0 = fRiseCnt; s0 = fRstCyc; e0 = fEnCyc; v0 = fStabViol; q0 = fRbQ.size();
      fStart = 1'b1;
      tick();
      fStart = 1'b0;
      repeat (3) tick();
      fStart = 1'b1;
      tick();
      fStart = 1'b0;
      n = 0;
      while (!fInReady && n < 60) begin
         tick();
         n++;
      end
      checkOutput("fast_ready", fInReady, 1);
      fInData = fb;
      fInValid = 1'b1;
      tick();
      fInValid = 1'b0;
      repeat (5) tick();
      fStart = 1'b1;
      tick();
      fStart = 1'b0;
      n = 0;
      while (!fDone && n < 100) begin
         tick();
         n++;
      end
      checkOutput("fast_done", {fDone, fBusy, fRbValid}, 3'b101);
      checkOutput("fast_en_cycles", fEnCyc - e0, 16);
      checkOutput("fast_rst_cycles", fRstCyc - s0, 8);
      checkOutput("fast_rise_cnt", fRiseCnt - r0, 8);
      checkOutput("fast_din_stable", fStabViol - v0, 0);
      checkOutput("fast_rb_count", fRbQ.size() - q0, 1);
      if (fRbQ.size() >= q0 + 1) checkOutput("fast_rb_byte", fRbQ[q0], fPreloadVal);
      checkOutput("fast_chain", fChain, fb);

      // Asynchronous reset in the middle of a shift.
      start = 1'b1;
      tick();
      start = 1'b0;
      sendByte(8'($urandom), 0, n, rbAt);
      repeat (6) tick();
      checkOutput("pre_reset_shift", {progEn, busy}, 2'b11);
      reset = 1'b1;
      #1;
      checkOutput("reset_async", {progClk, progRst, progEn, progDin, inReady, rbValid, busy, done, rbData}, 16'h0000);
      tick();
      tick();
      reset = 1'b0;
      repeat (3) tick();
      checkOutput("idle_after_mid_reset", {inReady, busy, done, progEn, progRst, progClk}, 6'b000000);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
